// File: rtl/aes_byte_scroller.sv
// aes_byte_scroller: captures a 128-bit AES block on a load strobe and
// presents it one byte at a time, least-significant byte first. The byte
// advances on a programmable time base or on a manual step edge, wrapping
// through all 16 bytes. Every output comes straight from a register.
module aes_byte_scroller #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] data_in,
  input  logic         step,
  input  logic         pause,
  output logic [7:0]   byte_out,
  output logic [3:0]   byte_idx,
  output logic         valid,
  output logic         wrapped
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  // Terminal count of the time base.
  localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);

  // FSM state register; a checker can bind to this directly.
  logic [0:0]   state;
  logic [127:0] block;
  logic [3:0]   idx;
  logic [31:0]  cnt;
  logic         step_d;

  logic         step_evt;
  logic         tick;
  logic         advance;
  logic [3:0]   idx_next;

  // Advance decode. A load in the same cycle suppresses any advance, and a
  // tick coinciding with a step edge still yields a single advance.
  always_comb begin
    step_evt = step & ~step_d;
    tick     = (state == SHOW) && !pause && (cnt == TICK_LAST);
    advance  = (state == SHOW) && !load && (tick || step_evt);
    idx_next = idx + 4'd1;
  end

  // FSM: IDLE until the first load, then SHOW until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (load) begin
      state <= SHOW;
    end
  end

  // Step edge detector; runs in both states so a step held across the
  // first load is not seen as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_d <= 1'b0;
    end else begin
      step_d <= step;
    end
  end

  // Time base: held at 0 in IDLE, frozen by pause, restarted by load,
  // by a step edge and on reaching the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 32'd0;
    end else if (load || state == IDLE) begin
      cnt <= 32'd0;
    end else if (step_evt || tick) begin
      cnt <= 32'd0;
    end else if (!pause) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Block register and byte index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block <= 128'd0;
      idx   <= 4'd0;
    end else if (load) begin
      block <= data_in;
      idx   <= 4'd0;
    end else if (advance) begin
      idx   <= idx_next;
    end
  end

  // Registered display outputs; byte_out is looked up with the next index
  // so it changes on the same edge as the index itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_out <= 8'd0;
      valid    <= 1'b0;
      wrapped  <= 1'b0;
    end else if (load) begin
      byte_out <= data_in[7:0];
      valid    <= 1'b1;
      wrapped  <= 1'b0;
    end else begin
      wrapped <= advance && (idx == 4'd15);
      if (advance) begin
        byte_out <= block[{idx_next, 3'b000} +: 8];
      end
    end
  end

  assign byte_idx = idx;

endmodule

// File: tb/tb_aes_byte_scroller.sv
// Directed testbench for aes_byte_scroller with TICK_CYCLES = 4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_aes_byte_scroller;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [127:0] data_in = 128'd0;
  logic         step = 1'b0;
  logic         pause = 1'b0;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         valid;
  logic         wrapped;

  int n_checks = 0;
  int n_fail   = 0;

  aes_byte_scroller #(.TICK_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .step     (step),
    .pause    (pause),
    .byte_out (byte_out),
    .byte_idx (byte_idx),
    .valid    (valid),
    .wrapped  (wrapped)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] make_block(input logic [7:0] base);
    logic [127:0] b;
    b = 128'd0;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = 8'(base + k);
    return b;
  endfunction

  task automatic do_load(input logic [127:0] d);
    data_in = d;
    load = 1'b1;
    clk_n(1);
    load = 1'b0;
  endtask

  // One manual step pulse: high for one edge, low for the next.
  task automatic step_pulse();
    step = 1'b1;
    clk_n(1);
    step = 1'b0;
    clk_n(1);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] b, input logic [3:0] ix,
                            input logic v, input logic w);
    check({tag, ".byte"}, 32'(byte_out), 32'(b));
    check({tag, ".idx"}, 32'(byte_idx), 32'(ix));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".wrap"}, 32'(wrapped), 32'(w));
  endtask

  initial begin
    // 1. Reset: asserted between edges, outputs zero immediately.
    #3 rst = 1'b1;
    #1 check_outs("rst_async", 8'h00, 4'd0, 1'b0, 1'b0);
    check("rst_state", 32'(dut.state), 32'd0);
    clk_n(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step = ~step;
      clk_n(1);
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_byte", 32'(byte_out), 32'd0);
      check("idle_idx", 32'(byte_idx), 32'd0);
    end
    step = 1'b0;
    clk_n(1);

    // 2. Load and auto-scroll: byte k = k, advance every 4 edges.
    do_load(make_block(8'h00));
    check_outs("load0", 8'h00, 4'd0, 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) begin
      clk_n(3);
      check("scroll_hold", 32'(byte_idx), 32'(k - 1));
      clk_n(1);
      check_outs("scroll", 8'(k), 4'(k), 1'b1, 1'b0);
    end
    clk_n(3);
    check("wrap_pre", 32'(wrapped), 32'd0);
    clk_n(1);
    check_outs("wrap", 8'h00, 4'd0, 1'b1, 1'b1);
    clk_n(1);
    check_outs("wrap_end", 8'h00, 4'd0, 1'b1, 1'b0);

    // 3. Pause and step.
    do_load(make_block(8'h10));
    clk_n(2);                       // counter now 2
    pause = 1'b1;
    clk_n(10);
    check_outs("paused", 8'h10, 4'd0, 1'b1, 1'b0);
    step = 1'b1;
    clk_n(1);
    check_outs("step_paused", 8'h11, 4'd1, 1'b1, 1'b0);
    clk_n(2);
    check("step_held", 32'(byte_idx), 32'd1);
    step = 1'b0;
    pause = 1'b0;
    clk_n(3);
    check("after_step_hold", 32'(byte_idx), 32'd1);
    clk_n(1);
    check_outs("after_step_adv", 8'h12, 4'd2, 1'b1, 1'b0);

    // 4a. Step edge on the same edge as the tick: single advance.
    clk_n(3);                       // counter now 3
    step = 1'b1;
    clk_n(1);
    step = 1'b0;
    check_outs("tick_step", 8'h13, 4'd3, 1'b1, 1'b0);
    clk_n(3);
    check("tick_step_hold", 32'(byte_idx), 32'd3);
    clk_n(1);
    check("tick_step_next", 32'(byte_idx), 32'd4);

    // 4b. Load coincident with a step edge at index 7.
    do_load(make_block(8'h20));
    for (int i = 0; i < 7; i++) step_pulse();
    check_outs("at7", 8'h27, 4'd7, 1'b1, 1'b0);
    step = 1'b1;
    do_load(make_block(8'h50));
    step = 1'b0;
    check_outs("load_step", 8'h50, 4'd0, 1'b1, 1'b0);
    clk_n(1);

    // 5. Async reset at index 9, then a fresh load.
    for (int i = 0; i < 9; i++) step_pulse();
    check_outs("at9", 8'h59, 4'd9, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_outs("rst_mid", 8'h00, 4'd0, 1'b0, 1'b0);
    check("rst_mid_state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    clk_n(6);
    check_outs("post_rst_idle", 8'h00, 4'd0, 1'b0, 1'b0);
    do_load(make_block(8'h60));
    check_outs("post_rst_load", 8'h60, 4'd0, 1'b1, 1'b0);
    clk_n(4);
    check_outs("post_rst_adv", 8'h61, 4'd1, 1'b1, 1'b0);

    // 6. Re-load in SHOW at index 5.
    for (int i = 0; i < 4; i++) step_pulse();
    check_outs("at5", 8'h65, 4'd5, 1'b1, 1'b0);
    do_load({16{8'hAA}});
    check_outs("reload", 8'hAA, 4'd0, 1'b1, 1'b0);
    clk_n(3);
    check("reload_hold", 32'(byte_idx), 32'd0);
    clk_n(1);
    check_outs("reload_adv", 8'hAA, 4'd1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
